count_snapshot_reader: RTL and testbench
========================================

// Module: count_snapshot_reader
// PURPOSE
// - Reader side of the design's wide free-running counter: captures a WIDTH-bit count value
//   atomically and streams it out one byte per transfer over a valid/ready handshake.
// - Exists because the tile has only 8 data output pins; it drives them together with the
//   handshake lines back to the external host.
// PARAMETERS
// - WIDTH      64  width of count_in; must be a multiple of 8, minimum 8
// - MSB_FIRST  0   0: byte 0 = count[7:0] is sent first; 1: most significant byte first
// PORTS
// - clk         in   1        rising-edge clock
// - rst         in   1        synchronous reset, active-high
// - count_in    in   WIDTH    live counter value to sample
// - start       in   1        level, sampled each clk; requests a snapshot + readout
// - data_out    out  8        current byte
// - valid       out  1        data_out holds a byte offered to the host
// - ready       in   1        host accepts data_out this cycle when valid & ready
// - last        out  1        high with valid on the final byte of the snapshot
// - busy        out  1        high from capture until the final byte is accepted
// - done        out  1        one-cycle pulse the cycle after the final byte is accepted
// - parity_out  out  1        odd parity of data_out (see CONFIGURATION)
// BEHAVIOUR
// - Reset: every register and output clears (state IDLE, byte index 0, snapshot 0).
//   data_out, valid, last, busy, done and parity_out all read 0.
//   Reset wins over every other input in the same cycle.
// - States:
//   - IDLE: valid=0, busy=0.
//   - SEND: valid=1, busy=1.
// - IDLE -> SEND on any clk edge with start=1. That same edge copies count_in into
//   the snapshot register and clears the byte index.
// - Latency: start high at edge N gives valid=1 with the first byte after edge N.
// - SEND: data_out = snapshot byte selected by the index and MSB_FIRST, registered
//   (no combinational path from count_in).
//   - valid & ready at an edge: that byte is consumed.
//   - Not the final byte: the index increments and the next byte is shown after the edge.
//   - ready=0: data_out, last and the index hold (no byte drop, no repeat).
// - Final byte: index = WIDTH/8-1, last=1. Accepting it returns the block to IDLE and
//   drives done=1 for exactly one cycle.
//   - start=1 on that same accept edge is ignored; the host must hold or re-raise start.
// - start while busy is ignored. The snapshot is never re-captured mid-readout, so all
//   bytes of one transfer belong to the same count sample (handles wrap-around, e.g. the
//   0x..FF -> 0x..00 carry between bytes).
// - Holding start=1 continuously gives back-to-back snapshots separated by one IDLE cycle.
// - rst mid-readout aborts the transfer: no done pulse; the partial snapshot is discarded.
// - WIDTH=8: a single byte with last=1 on it.
// CONFIGURATION
// - Macro COUNT_SNAPSHOT_PARITY_EN.
//   - Defined: parity_out = ~^data_out (odd parity), registered alongside data_out;
//     0 in IDLE and at reset.
//   - Undefined: parity_out is tied to 0 and no parity logic is built.
//   - The port exists in both builds so the pinout does not change.
// TESTING
// 1. rst=1 for 2 cycles with start=1 -> all outputs 0, state IDLE, no capture.
// 2. WIDTH=64, MSB_FIRST=0, count_in=64'h0807060504030201, start 1 cycle, ready=1 ->
//    bytes 01..08 on 8 consecutive cycles; last only on 08; done 1 cycle later; busy=0 after.
// 3. Same value, MSB_FIRST=1, ready toggling 1,0,1,0 -> bytes 08..01, each held while ready=0;
//    count_in changing during the readout does not alter the bytes sent.
// 4. count_in increments every cycle from 64'h00000000000000FF; start -> streamed bytes
//    are FF,00,00,00,00,00,00,00 (single consistent sample).
// 5. start held high throughout the readout -> no recapture before done.
//    - Next capture occurs one IDLE cycle later.
//    - rst asserted at byte 3 -> valid=0 next cycle, no done.
// 6. With COUNT_SNAPSHOT_PARITY_EN, data_out=8'h03 -> parity_out=1; 8'h07 -> parity_out=0.
//    Without the macro -> parity_out=0 always.

Source files
------------

// File: rtl/count_snapshot_reader.sv
// Atomic snapshot of a WIDTH-bit counter streamed out one byte per valid/ready transfer.
// Optional odd parity on the data byte is built when COUNT_SNAPSHOT_PARITY_EN is defined.
module count_snapshot_reader #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             start,
  output logic [7:0]       data_out,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             parity_out
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] snapshot;
  logic [IDXW-1:0]  index;
  logic [IDXW-1:0]  next_index;
  logic [7:0]       data_nxt;
  logic             show_nxt;

  function automatic logic [7:0] byte_of(input logic [WIDTH-1:0] value,
                                         input logic [IDXW-1:0] idx);
    int unsigned pos;
    pos = MSB_FIRST ? (NBYTES - 32'd1 - 32'(idx)) : 32'(idx);
    return value[pos*8 +: 8];
  endfunction

  assign next_index = index + IDXW'(1);

  // The byte (and whether it is offered) that appears after the coming edge.
  always_comb begin
    data_nxt = data_out;
    show_nxt = valid;
    case (state)
      IDLE: begin
        if (start) begin
          data_nxt = byte_of(count_in, '0);
          show_nxt = 1'b1;
        end else begin
          data_nxt = 8'h00;
          show_nxt = 1'b0;
        end
      end
      SEND: begin
        if (ready && (index == LAST_IDX)) begin
          data_nxt = 8'h00;
          show_nxt = 1'b0;
        end else if (ready) begin
          data_nxt = byte_of(snapshot, next_index);
          show_nxt = 1'b1;
        end else begin
          data_nxt = data_out;
          show_nxt = 1'b1;
        end
      end
      default: begin
        data_nxt = 8'h00;
        show_nxt = 1'b0;
      end
    endcase
  end

  // Readout FSM; the snapshot is only loaded from IDLE so a transfer never mixes samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      snapshot <= '0;
      index    <= '0;
      data_out <= 8'h00;
      valid    <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      data_out <= data_nxt;
      valid    <= show_nxt;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SEND;
            snapshot <= count_in;
            index    <= '0;
            busy     <= 1'b1;
            last     <= (LAST_IDX == '0);
          end else begin
            busy <= 1'b0;
            last <= 1'b0;
          end
        end
        SEND: begin
          if (ready && (index == LAST_IDX)) begin
            state <= IDLE;
            index <= '0;
            busy  <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b1;
          end else if (ready) begin
            index <= next_index;
            last  <= (next_index == LAST_IDX);
          end else begin
            index <= index;
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
          busy  <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_SNAPSHOT_PARITY_EN
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Parity register tracks data_out and reads 0 whenever no byte is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_out <= 1'b0;
    end else begin
      parity_out <= show_nxt & odd_parity(data_nxt);
    end
  end
`else
  assign parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_count_snapshot_reader.sv
// Directed bench for count_snapshot_reader: LSB-first, MSB-first with back-pressure, and WIDTH=8.
module tb_count_snapshot_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] count;
  logic        start0, ready0, start1, ready1, start8, ready8;
  logic [7:0]  data0, data1, data8;
  logic        valid0, last0, busy0, done0, par0;
  logic        valid1, last1, busy1, done1, par1;
  logic        valid8, last8, busy8, done8, par8;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  count_snapshot_reader #(.WIDTH(64), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .count_in(count), .start(start0), .data_out(data0),
    .valid(valid0), .ready(ready0), .last(last0), .busy(busy0), .done(done0),
    .parity_out(par0));

  count_snapshot_reader #(.WIDTH(64), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .count_in(count), .start(start1), .data_out(data1),
    .valid(valid1), .ready(ready1), .last(last1), .busy(busy1), .done(done1),
    .parity_out(par1));

  count_snapshot_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .count_in(count[7:0]), .start(start8), .data_out(data8),
    .valid(valid8), .ready(ready8), .last(last8), .busy(busy8), .done(done8),
    .parity_out(par8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_par(input logic [7:0] b);
`ifdef COUNT_SNAPSHOT_PARITY_EN
    return ~^b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] d, input logic v, input logic l, input logic b,
                     input logic dn, input logic p,
                     input logic [7:0] ed, input logic ev, input logic el, input logic eb,
                     input logic edn);
    check({tag, " data"}, 64'(d), 64'(ed));
    check({tag, " valid"}, 64'(v), 64'(ev));
    check({tag, " last"}, 64'(l), 64'(el));
    check({tag, " busy"}, 64'(b), 64'(eb));
    check({tag, " done"}, 64'(dn), 64'(edn));
    check({tag, " parity"}, 64'(p), 64'(ev ? exp_par(ed) : 1'b0));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] a_v;
  logic [63:0] b_v;
  int          k;

  initial begin
    rst = 1'b1; count = 64'h0807060504030201;
    start0 = 1'b1; start1 = 1'b1; start8 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready8 = 1'b1;

    // reset with start high: nothing captured, everything low
    step; step;
    chk("rst d0", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst d1", data1, valid1, last1, busy1, done1, par1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst d8", data8, valid8, last8, busy8, done8, par8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start8 = 1'b0;
    step;
    chk("idle d0", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // LSB first, ready always high
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb b%0d", i), data0, valid0, last0, busy0, done0, par0,
          8'(i + 1), 1'b1, (i == 7), 1'b1, 1'b0);
      step;
    end
    chk("lsb end", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step;
    chk("lsb after", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB first, ready toggling, count_in moving during readout
    start1 = 1'b1;
    step;
    start1 = 1'b0;
    k = 0;
    for (int c = 0; c < 16 && k < 8; c++) begin
      ready1 = (c % 2 == 0);
      chk($sformatf("msb c%0d", c), data1, valid1, last1, busy1, done1, par1,
          8'(8 - k), 1'b1, (k == 7), 1'b1, 1'b0);
      count = count + 64'h0101010101010101;
      step;
      if (ready1) k++;
    end
    ready1 = 1'b1;
    check("msb bytes", 64'(k), 64'd8);
    chk("msb end", data1, valid1, last1, busy1, done1, par1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // carry between bytes while counting: one consistent sample
    count = 64'h00000000000000FF;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap b%0d", i), data0, valid0, last0, busy0, done0, par0,
          (i == 0) ? 8'hFF : 8'h00, 1'b1, (i == 7), 1'b1, 1'b0);
      count = count + 64'd1;
      step;
    end
    chk("wrap end", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // start held: no recapture mid-readout, next capture after one IDLE cycle, then abort
    a_v = 64'h1122334455667788;
    b_v = 64'h99AABBCCDDEEFF00;
    count = a_v;
    start0 = 1'b1;
    step;
    count = b_v;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hold b%0d", i), data0, valid0, last0, busy0, done0, par0,
          a_v[8*i +: 8], 1'b1, (i == 7), 1'b1, 1'b0);
      step;
    end
    chk("hold idle", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step;
    chk("recap b0", data0, valid0, last0, busy0, done0, par0, b_v[7:0], 1'b1, 1'b0, 1'b1, 1'b0);
    step; step; step;
    chk("recap b3", data0, valid0, last0, busy0, done0, par0, b_v[31:24], 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; start0 = 1'b0;
    step;
    chk("abort", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step;
    chk("abort after", data0, valid0, last0, busy0, done0, par0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8: single byte flagged last
    count = 64'h00000000000000A5;
    start8 = 1'b1;
    step;
    start8 = 1'b0;
    chk("w8 b0", data8, valid8, last8, busy8, done8, par8, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    step;
    chk("w8 end", data8, valid8, last8, busy8, done8, par8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step;
    chk("w8 after", data8, valid8, last8, busy8, done8, par8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
